// File: rtl/reg_file_sb.sv
// Integer register file with an integrated pending-write scoreboard.
// It has two combinational read ports with write-first bypass and one write port.
// x0 is hardwired to zero. Each register tracks whether an issued producer
// has not yet written back, so decode can detect RAW hazards directly.

// One architectural register: its data word and its pending bit.
module reg_file_sb_ent #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wd,
  input  logic            set_en,
  input  logic            flush,
  output logic [XLEN-1:0] data_q,
  output logic            pend_q,
  output logic            pend_nxt
);
  // Next pending state: flush beats a new issue, and a new issue beats writeback.
  // On a same-cycle issue and writeback, the newer producer stays outstanding.
  always_comb begin
    pend_nxt = pend_q;
    if (flush)       pend_nxt = 1'b0;
    else if (set_en) pend_nxt = 1'b1;
    else if (wr_en)  pend_nxt = 1'b0;
  end

  // Data and pending state. A flush does not stop the data write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      pend_q <= 1'b0;
    end else begin
      if (wr_en) data_q <= wd;
      pend_q <= pend_nxt;
    end
  end
endmodule

module reg_file_sb #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] wd,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            flush,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic [AW:0]     pending_cnt,
  output logic            wb_err
);
  logic [NREGS-1:0][XLEN-1:0] rf_q;
  logic [NREGS-1:0]           pend_q;
  logic [NREGS-1:0]           pend_nxt;
  logic [AW:0]                cnt_nxt;

  // x0 has no storage and is never pending.
  assign rf_q[0]     = '0;
  assign pend_q[0]   = 1'b0;
  assign pend_nxt[0] = 1'b0;

  for (genvar g = 1; g < NREGS; g++) begin : g_ent
    reg_file_sb_ent #(.XLEN(XLEN)) u_ent (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (we && (rd_addr == AW'(g))),
      .wd       (wd),
      .set_en   (issue_valid && (issue_rd == AW'(g))),
      .flush    (flush),
      .data_q   (rf_q[g]),
      .pend_q   (pend_q[g]),
      .pend_nxt (pend_nxt[g])
    );
  end

  // Read ports: x0 reads zero, then a same-cycle writeback is bypassed, then stored data is used.
  always_comb begin
    rs1_data = rf_q[rs1_addr];
    rs2_data = rf_q[rs2_addr];
    if (we && (rd_addr == rs1_addr)) rs1_data = wd;
    if (we && (rd_addr == rs2_addr)) rs2_data = wd;
    if (rs1_addr == '0) rs1_data = '0;
    if (rs2_addr == '0) rs2_data = '0;
  end

  // A writeback in the same cycle satisfies the hazard through the bypass.
  // This uses registered pending bits only, so issue_valid has no combinational path here.
  always_comb begin
    rs1_busy = pend_q[rs1_addr] && !(we && (rd_addr == rs1_addr));
    rs2_busy = pend_q[rs2_addr] && !(we && (rd_addr == rs2_addr));
  end

  // Popcount of the next pending vector. The count register then changes on the same edge as the bits.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++) cnt_nxt = cnt_nxt + (AW+1)'(pend_nxt[i]);
  end

  // Pending count, and a sticky flag for writebacks that have no outstanding producer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_cnt <= '0;
      wb_err      <= 1'b0;
    end else begin
      pending_cnt <= cnt_nxt;
      if (we && (rd_addr != '0) && !pend_q[rd_addr] && !flush) wb_err <= 1'b1;
    end
  end
endmodule
